// File: rtl/snake_px_pkg.sv
// snake_px_pkg: shared definitions for the snake pixel-drawing engine.
//   - command opcodes and command word layout
//   - engine FSM state encoding
//   - status register bit positions
//   - palette reset colours (RGB565)
package snake_px_pkg;

  localparam logic [3:0] OP_CELL       = 4'h1;
  localparam logic [3:0] OP_CLEAR      = 4'h2;
  localparam logic [3:0] OP_SOFT_RESET = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DRAW   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] pal;
    logic [9:0] cy;
    logic [5:0] rsvd;
    logic [9:0] cx;
  } cmd_t;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_BAD_OP    = 3;
  localparam int unsigned STAT_OVERFLOW  = 4;
  localparam int unsigned STAT_LEVEL_LSB = 8;

  function automatic logic [15:0] pal_reset(input logic [1:0] idx);
    case (idx)
      2'd0:    return 16'h0000;
      2'd1:    return 16'h07E0;
      2'd2:    return 16'hF800;
      default: return 16'hFFE0;
    endcase
  endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// snake_cmd_fifo: synchronous show-ahead command FIFO.
//   clk_i/rst_i  clock, asynchronous active-high reset
//   push_i       write din_i (ignored when full)
//   pop_i        drop head entry (ignored when empty); dout_o is the head
//   flush_i      empty the FIFO; overrides push/pop in the same cycle
//   full_o/empty_o/level_o  occupancy flags and entry count
module snake_cmd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/snake_px_engine.sv
// snake_px_engine: queued cell-fill / screen-clear engine for the snake game.
//   HPS slave : hps_address (0 = command/status, 1..4 = palette), hps_read,
//               hps_write, hps_writedata, hps_readdata, hps_waitrequest
//   VGA master: vga_px_address, vga_px_write, vga_px_writedata,
//               vga_px_waitrequest (one RGB565 pixel per accepted transfer)
//   busy_export: engine drawing or commands still queued
module snake_px_engine
  import snake_px_pkg::*;
#(
  parameter logic [31:0] VGA_BASE   = 32'h0800_0000,
  parameter int unsigned H_PIXELS   = 320,
  parameter int unsigned V_PIXELS   = 240,
  parameter int unsigned CELL_SIZE  = 4,
  parameter int unsigned X_SHIFT    = 1,
  parameter int unsigned Y_SHIFT    = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  hps_address,
  input  logic        hps_read,
  input  logic        hps_write,
  input  logic [31:0] hps_writedata,
  output logic [31:0] hps_readdata,
  output logic        hps_waitrequest,
  output logic [31:0] vga_px_address,
  output logic        vga_px_write,
  output logic [15:0] vga_px_writedata,
  input  logic        vga_px_waitrequest,
  output logic        busy_export
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [31:0] px_addr(input logic [9:0] x, input logic [9:0] y);
    return VGA_BASE | (32'(y) << Y_SHIFT) | (32'(x) << X_SHIFT);
  endfunction

  state_e      state_q;
  logic [3:0]  op_q;
  logic [1:0]  pal_sel_q;
  logic [9:0]  cx_q, cy_q;
  logic [9:0]  px_q, py_q, xs_q, xl_q, yl_q;
  logic [31:0] addr_q;
  logic [15:0] data_q;
  logic        write_q;
  logic        bad_op_q;
  logic        soft_pend_q;
  logic [15:0] pal_q [4];

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]   fifo_dout;
  logic [LW-1:0] fifo_level;
  cmd_t          wr_cmd, head_cmd;
  logic          unused_rsvd;

  logic        cmd_sel, soft_acc, hold, soft_now, stat_rd, pal_we;
  logic [1:0]  pal_wr_idx;

  logic [31:0] px0_d, py0_d;
  logic        valid_d;
  logic [9:0]  xs_d, ys_d, xl_d, yl_d;
  logic        last_x_d, done_d;
  logic [9:0]  nx_px_d, nx_py_d;

  assign wr_cmd      = cmd_t'(hps_writedata);
  assign head_cmd    = cmd_t'(fifo_dout);
  assign unused_rsvd = ^head_cmd.rsvd;

  assign cmd_sel         = hps_write && (hps_address == 4'd0);
  assign hps_waitrequest = cmd_sel && fifo_full;
  assign soft_acc        = cmd_sel && !fifo_full && (wr_cmd.op == OP_SOFT_RESET);
  assign fifo_push       = cmd_sel && (wr_cmd.op != OP_SOFT_RESET);
  assign stat_rd         = hps_read && (hps_address == 4'd0);
  assign pal_we          = hps_write && (hps_address >= 4'd1) && (hps_address <= 4'd4);
  assign pal_wr_idx      = 2'(hps_address - 4'd1);

  // A soft reset must not abandon a transfer the slave is stalling; it is
  // parked in soft_pend_q until the held write is accepted.
  assign hold       = write_q && vga_px_waitrequest;
  assign soft_now   = (soft_acc || soft_pend_q) && !hold;
  assign fifo_flush = soft_now;
  assign fifo_pop   = (state_q == ST_IDLE) && !soft_now;

  snake_cmd_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .din_i   (hps_writedata),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    px0_d   = 32'(cx_q) * CELL_SIZE;
    py0_d   = 32'(cy_q) * CELL_SIZE;
    valid_d = 1'b0;
    xs_d    = '0;
    ys_d    = '0;
    xl_d    = '0;
    yl_d    = '0;
    case (op_q)
      OP_CELL: begin
        valid_d = (px0_d + CELL_SIZE <= H_PIXELS) && (py0_d + CELL_SIZE <= V_PIXELS);
        xs_d    = px0_d[9:0];
        ys_d    = py0_d[9:0];
        xl_d    = 10'(px0_d + CELL_SIZE - 1);
        yl_d    = 10'(py0_d + CELL_SIZE - 1);
      end
      OP_CLEAR: begin
        valid_d = 1'b1;
        xl_d    = 10'(H_PIXELS - 1);
        yl_d    = 10'(V_PIXELS - 1);
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_comb begin
    last_x_d = (px_q == xl_q);
    done_d   = last_x_d && (py_q == yl_q);
    nx_px_d  = last_x_d ? xs_q : px_q + 10'd1;
    nx_py_d  = last_x_d ? py_q + 10'd1 : py_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      pal_sel_q   <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      xs_q        <= '0;
      xl_q        <= '0;
      yl_q        <= '0;
      addr_q      <= VGA_BASE;
      data_q      <= '0;
      write_q     <= 1'b0;
      bad_op_q    <= 1'b0;
      soft_pend_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) pal_q[i] <= pal_reset(2'(i));
    end else begin
      if (pal_we)  pal_q[pal_wr_idx] <= hps_writedata[15:0];
      if (stat_rd) bad_op_q <= 1'b0;
      if (soft_now) begin
        state_q     <= ST_IDLE;
        write_q     <= 1'b0;
        bad_op_q    <= 1'b0;
        soft_pend_q <= 1'b0;
      end else begin
        if (soft_acc) soft_pend_q <= 1'b1;
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty) begin
              op_q      <= head_cmd.op;
              pal_sel_q <= head_cmd.pal;
              cx_q      <= head_cmd.cx;
              cy_q      <= head_cmd.cy;
              state_q   <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            if (valid_d) begin
              xs_q    <= xs_d;
              xl_q    <= xl_d;
              yl_q    <= yl_d;
              px_q    <= xs_d;
              py_q    <= ys_d;
              addr_q  <= px_addr(xs_d, ys_d);
              data_q  <= pal_q[pal_sel_q];
              write_q <= 1'b1;
              state_q <= ST_DRAW;
            end else begin
              bad_op_q <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end
          ST_DRAW: begin
            if (!vga_px_waitrequest) begin
              if (done_d) begin
                write_q <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                px_q   <= nx_px_d;
                py_q   <= nx_py_d;
                addr_q <= px_addr(nx_px_d, nx_py_d);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign vga_px_address   = addr_q;
  assign vga_px_write     = write_q;
  assign vga_px_writedata = data_q;
  assign busy_export      = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    hps_readdata = '0;
    case (hps_address)
      4'd0: begin
        hps_readdata[STAT_BUSY]     = busy_export;
        hps_readdata[STAT_EMPTY]    = fifo_empty;
        hps_readdata[STAT_FULL]     = fifo_full;
        hps_readdata[STAT_BAD_OP]   = bad_op_q;
        hps_readdata[STAT_OVERFLOW] = 1'b0;
        hps_readdata[STAT_LEVEL_LSB +: 8] = 8'(fifo_level);
      end
      4'd1:    hps_readdata = {16'h0000, pal_q[0]};
      4'd2:    hps_readdata = {16'h0000, pal_q[1]};
      4'd3:    hps_readdata = {16'h0000, pal_q[2]};
      4'd4:    hps_readdata = {16'h0000, pal_q[3]};
      default: hps_readdata = '0;
    endcase
  end

endmodule
